mem_wb_pipe: RTL and testbench
==============================

Name: mem_wb_pipe

Overview:
- Holds the EX/MEM and MEM/WB pipeline registers of the OTTER 5-stage core.
- Runs the data-memory request/acknowledge handshake and aligns and sign-extends load data.
- Stalls the front of the pipeline while memory is busy.
- Produces the rd, regWrite and result signals that the forwarding unit and the register file consume.

Parameters:
- TIMEOUT, 16, number of WAIT cycles without dmem_ack before the access is abandoned (range 2..255).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX holds a real instruction (0 = bubble).
- ex_rd  in  5  destination register.
- ex_regWrite  in  1  instruction writes the register file.
- ex_memRead  in  1  instruction is a load.
- ex_memWrite  in  1  instruction is a store.
- ex_rf_wr_sel  in  2  writeback source: 00 = ALU, 01 = memory, 10 = pc+4.
- ex_size  in  2  access size: 00 = byte, 01 = half, 10 = word.
- ex_sign  in  1  load is sign-extended.
- ex_alu_result  in  32  ALU result, also the memory address.
- ex_rs2_data  in  32  store data, already forwarded.
- ex_pc_plus4  in  32  link value.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word-aligned address.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_ack  in  1  memory completes the access this cycle.
- dmem_rdata  in  32  raw read word.
- mem_stall  out  1  freeze PC, IF/ID and ID/EX.
- ex_mem_rd  out  5  EX/MEM destination.
- ex_mem_regWrite  out  1  EX/MEM will write.
- ex_mem_fwd_data  out  32  EX/MEM forwarding value.
- mem_wb_rd  out  5  MEM/WB destination.
- mem_wb_regWrite  out  1  MEM/WB write enable to the register file.
- wb_data  out  32  writeback and forwarding value.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high.
  - All pipeline registers clear on reset.
  - All outputs are 0 on reset, the FSM enters IDLE, and the wait counter is 0.
  - Reset mid-access drops dmem_req in the same cycle, combinationally through the cleared registers.
- EX/MEM capture:
  - Loads from the ex_* inputs on a clock edge when mem_stall = 0.
  - If ex_valid = 0, it captures a bubble: regWrite, memRead and memWrite all 0.
- Memory operation pending: mem_op = EX/MEM valid & (memRead | memWrite).
- Request outputs:
  - dmem_req = mem_op & !done, combinational. done is set only by the timeout path.
  - dmem_we = memWrite.
  - dmem_addr = {alu_result[31:2], 2'b00}.
  - Byte: dmem_be = 0001 << addr[1:0]; dmem_wdata = {4{rs2[7:0]}}.
  - Half: dmem_be = 0011 << {addr[1], 1'b0}; dmem_wdata = {2{rs2[15:0]}}.
  - Word: dmem_be = 1111; dmem_wdata = rs2.
  - Misaligned accesses are the upstream unit's responsibility; addr[0] is ignored for halves.
- Stall: mem_stall = dmem_req & !dmem_ack.
  - While mem_stall = 1, EX/MEM and MEM/WB both hold their contents.
  - Re-writing the same MEM/WB value is idempotent.
- FSM:
  - IDLE -> WAIT when dmem_req & !dmem_ack.
  - WAIT -> IDLE on dmem_ack.
  - A zero-wait ack (ack in the first request cycle) stays in IDLE and produces no stall.
- Wait counter:
  - Increments each cycle spent in WAIT and clears on leaving WAIT.
- Timeout:
  - When the counter reaches TIMEOUT-1 in WAIT without an ack, the next edge sets bus_err (sticky until rst), sets done and returns to IDLE.
  - mem_stall is 0 in that final cycle.
  - The access advances to MEM/WB with regWrite forced to 0.
- MEM/WB capture:
  - Captured when mem_stall = 0: rd, regWrite and the writeback value.
  - Writeback value for rf_wr_sel = 00: alu_result.
  - For 10: pc_plus4.
  - For 01: dmem_rdata shifted right by 8*addr[1:0] and then extended. Byte: bits [7:0]. Half: bits [15:0]. Extension is sign or zero per ex_sign.
- Forwarding data:
  - ex_mem_fwd_data = pc_plus4 when rf_wr_sel = 10, otherwise alu_result.
  - For loads it is not meaningful; the load-use stall upstream guarantees it is never consumed.
- Writeback: wb_data is the registered MEM/WB value.
- rd = 0: carried unchanged; the consumers ignore x0.

Test Plan:
- ALU writeback: ADD with rd = 5, alu = 0x1234, no memory -> next cycle ex_mem_rd = 5, ex_mem_fwd_data = 0x1234; the cycle after, mem_wb_rd = 5, mem_wb_regWrite = 1, wb_data = 0x1234.
- Zero-wait signed byte load: LB at address 0x103, ack in the same cycle, rdata = 0x80FF_0000 -> dmem_be = 1000, mem_stall never asserted, wb_data = 0xFFFF_FF80.
- Half store with 3 wait cycles: SH at address 0x202, rs2 = 0xABCD -> dmem_be = 1100, dmem_wdata = 0xABCD_ABCD, mem_stall high for exactly 3 cycles, mem_wb_regWrite = 0.
- Timeout with TIMEOUT = 4: LW with dmem_ack held low -> dmem_req drops after 5 request cycles, bus_err = 1 and stays 1, load retires with mem_wb_regWrite = 0, the next instruction proceeds.
- Bubbles and rst: ex_valid = 0 for 2 cycles -> ex_mem_regWrite = 0 and mem_wb_regWrite = 0. rst asserted mid-WAIT -> dmem_req = 0 immediately, bus_err = 0, all outputs 0.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: EX/MEM and MEM/WB pipeline registers of the OTTER core, with the
//   data-memory request/ack handshake, store lane steering and load alignment.
// Latency: one edge EX->EX/MEM, one more edge EX/MEM->MEM/WB; memory ops add
//   one cycle per wait state.
// Backpressure: mem_stall (req & !ack) freezes PC, IF/ID, ID/EX and both local
//   stages; a TIMEOUT-cycle wait abandons the access with bus_err.
//
// Ports:
//   clk, rst                  core clock, asynchronous active-high reset
//   ex_*                      instruction leaving EX (control, ALU result, store data, link)
//   dmem_req/we/addr/be/wdata request to data memory (combinational from EX/MEM)
//   dmem_ack, dmem_rdata      memory completion and raw read word
//   mem_stall                 front-of-pipe freeze
//   ex_mem_rd/regWrite/fwd_data   EX/MEM forwarding view
//   mem_wb_rd/regWrite, wb_data   MEM/WB register-file write and forwarding view
//   bus_err                   sticky timeout flag
module mem_wb_pipe #(
  parameter int unsigned TIMEOUT = 16  // 2..255 wait cycles before abandoning an access
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regWrite,
  input  logic        ex_memRead,
  input  logic        ex_memWrite,
  input  logic [1:0]  ex_rf_wr_sel,
  input  logic [1:0]  ex_size,
  input  logic        ex_sign,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_rs2_data,
  input  logic [31:0] ex_pc_plus4,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [4:0]  ex_mem_rd,
  output logic        ex_mem_regWrite,
  output logic [31:0] ex_mem_fwd_data,
  output logic [4:0]  mem_wb_rd,
  output logic        mem_wb_regWrite,
  output logic [31:0] wb_data,
  output logic        bus_err
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // EX/MEM stage
  // ---------------------------------------------------------------------------
  logic        em_valid_q;
  logic [4:0]  em_rd_q;
  logic        em_rw_q;
  logic        em_mr_q;
  logic        em_mw_q;
  logic [1:0]  em_sel_q;
  logic [1:0]  em_size_q;
  logic        em_sign_q;
  logic [31:0] em_alu_q;
  logic [31:0] em_rs2_q;
  logic [31:0] em_pc4_q;

  // MEM/WB stage
  logic [4:0]  mw_rd_q;
  logic        mw_rw_q;
  logic [31:0] mw_data_q;
  logic [31:0] mw_data_d;

  // Handshake control
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        bus_err_q, bus_err_d;

  logic        mem_op;
  logic        timeout_hit;

  // A bubble must never write or touch memory, so its control bits are
  // squashed at capture; the data fields are don't-care and load as-is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      em_valid_q <= 1'b0;
      em_rd_q    <= 5'd0;
      em_rw_q    <= 1'b0;
      em_mr_q    <= 1'b0;
      em_mw_q    <= 1'b0;
      em_sel_q   <= 2'b00;
      em_size_q  <= 2'b00;
      em_sign_q  <= 1'b0;
      em_alu_q   <= 32'd0;
      em_rs2_q   <= 32'd0;
      em_pc4_q   <= 32'd0;
    end else if (!mem_stall) begin
      em_valid_q <= ex_valid;
      em_rd_q    <= ex_rd;
      em_rw_q    <= ex_valid & ex_regWrite;
      em_mr_q    <= ex_valid & ex_memRead;
      em_mw_q    <= ex_valid & ex_memWrite;
      em_sel_q   <= ex_rf_wr_sel;
      em_size_q  <= ex_size;
      em_sign_q  <= ex_sign;
      em_alu_q   <= ex_alu_result;
      em_rs2_q   <= ex_rs2_data;
      em_pc4_q   <= ex_pc_plus4;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory request
  // ---------------------------------------------------------------------------
  assign mem_op    = em_valid_q & (em_mr_q | em_mw_q);
  assign dmem_req  = mem_op & ~done_q;
  assign dmem_we   = em_mw_q;
  assign dmem_addr = {em_alu_q[31:2], 2'b00};

  // Last WAIT cycle with no ack: the access is abandoned, so the pipeline is
  // released this cycle instead of on the next one.
  assign timeout_hit = (state_q == S_WAIT) && (cnt_q == CNT_LAST) && !dmem_ack;
  assign mem_stall   = dmem_req & ~dmem_ack & ~timeout_hit;

  // Store data is replicated across lanes so the byte enables alone pick the
  // target bytes. Half accesses use addr[1] only; alignment is checked upstream.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = em_rs2_q;
    case (em_size_q)
      SZ_BYTE: begin
        dmem_be    = 4'b0001 << em_alu_q[1:0];
        dmem_wdata = {4{em_rs2_q[7:0]}};
      end
      SZ_HALF: begin
        dmem_be    = 4'b0011 << {em_alu_q[1], 1'b0};
        dmem_wdata = {2{em_rs2_q[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = em_rs2_q;
      end
    endcase
    // Keep the byte enables quiet when no access is in flight.
    if (!mem_op) begin
      dmem_be = 4'b0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM and wait counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      done_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    bus_err_d = bus_err_q | timeout_hit;

    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        // A zero-wait ack completes without ever entering WAIT.
        if (dmem_req && !dmem_ack) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_ack || timeout_hit || !dmem_req) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // done marks the EX/MEM entry whose access was abandoned. The stall is
    // released in the timeout cycle, so that entry is replaced on the same
    // edge; a freshly captured entry always starts not-done.
    if (timeout_hit) begin
      done_d = 1'b1;
    end
    if (!mem_stall) begin
      done_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Load alignment and writeback select
  // ---------------------------------------------------------------------------
  logic [31:0] load_sh;
  logic [31:0] load_val;

  assign load_sh = dmem_rdata >> {em_alu_q[1:0], 3'b000};

  always_comb begin
    load_val = load_sh;
    case (em_size_q)
      SZ_BYTE: load_val = {{24{load_sh[7]  & em_sign_q}}, load_sh[7:0]};
      SZ_HALF: load_val = {{16{load_sh[15] & em_sign_q}}, load_sh[15:0]};
      default: load_val = load_sh;
    endcase
  end

  always_comb begin
    mw_data_d = em_alu_q;
    case (em_sel_q)
      SEL_MEM: mw_data_d = load_val;
      SEL_PC4: mw_data_d = em_pc4_q;
      default: mw_data_d = em_alu_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MEM/WB stage
  // ---------------------------------------------------------------------------
  // Holding while stalled re-presents the same value to the register file,
  // which is harmless. An abandoned load retires without writing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mw_rd_q   <= 5'd0;
      mw_rw_q   <= 1'b0;
      mw_data_q <= 32'd0;
    end else if (!mem_stall) begin
      mw_rd_q   <= em_rd_q;
      mw_rw_q   <= em_rw_q & ~timeout_hit;
      mw_data_q <= mw_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Loads are never forwarded from EX/MEM (the load-use stall prevents it),
  // so only ALU and link values matter here.
  assign ex_mem_rd        = em_rd_q;
  assign ex_mem_regWrite  = em_rw_q;
  assign ex_mem_fwd_data  = (em_sel_q == SEL_PC4) ? em_pc4_q : em_alu_q;

  assign mem_wb_rd        = mw_rd_q;
  assign mem_wb_regWrite  = mw_rw_q;
  assign wb_data          = mw_data_q;

  assign bus_err          = bus_err_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: randomized instruction stream against a transaction-level
//   model of the EX/MEM -> MEM/WB pipeline and its memory handshake.
// Each memory op carries its own ack latency (or never acks); the model counts
//   request cycles per op and derives stall, timeout and writeback from that.
module tb_mem_wb_pipe;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_regWrite;
  logic        ex_memRead;
  logic        ex_memWrite;
  logic [1:0]  ex_rf_wr_sel;
  logic [1:0]  ex_size;
  logic        ex_sign;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_pc_plus4;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_regWrite;
  logic [31:0] ex_mem_fwd_data;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_regWrite;
  logic [31:0] wb_data;
  logic        bus_err;

  mem_wb_pipe #(.TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_rd           (ex_rd),
    .ex_regWrite     (ex_regWrite),
    .ex_memRead      (ex_memRead),
    .ex_memWrite     (ex_memWrite),
    .ex_rf_wr_sel    (ex_rf_wr_sel),
    .ex_size         (ex_size),
    .ex_sign         (ex_sign),
    .ex_alu_result   (ex_alu_result),
    .ex_rs2_data     (ex_rs2_data),
    .ex_pc_plus4     (ex_pc_plus4),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_ack        (dmem_ack),
    .dmem_rdata      (dmem_rdata),
    .mem_stall       (mem_stall),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_regWrite (ex_mem_regWrite),
    .ex_mem_fwd_data (ex_mem_fwd_data),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_regWrite (mem_wb_regWrite),
    .wb_data         (wb_data),
    .bus_err         (bus_err)
  );

  always #5 clk = ~clk;

  // One instruction as seen leaving EX, plus the memory behaviour it will meet.
  typedef struct {
    bit        valid;
    bit [4:0]  rd;
    bit        rw, mr, mw;
    bit [1:0]  sel, size;
    bit        sgn;
    bit [31:0] alu, rs2, pc4, rdata;
    int        lat;   // ack in request cycle 'lat' (0 = zero-wait); -1 = never
  } ins_t;

  ins_t      q[$];
  ins_t      em;        // model of the instruction held in EX/MEM
  int        k;         // request cycles already spent by em
  bit [4:0]  m_rd;
  bit        m_rw;
  bit [31:0] m_data;
  bit        m_berr;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %h, want %h", tag, $time, got, exp);
  endtask

  function automatic ins_t blank();
    ins_t b;
    b = '{default: 0};
    return b;
  endfunction

  function automatic ins_t mk(input bit v, input bit [4:0] rd, input bit rw, input bit mr,
                              input bit mw, input bit [1:0] sel, input bit [1:0] size,
                              input bit sgn, input bit [31:0] alu, input bit [31:0] rs2,
                              input bit [31:0] rdata, input int lat);
    ins_t i;
    i = blank();
    i.valid = v; i.rd = rd; i.rw = rw; i.mr = mr; i.mw = mw; i.sel = sel;
    i.size = size; i.sgn = sgn; i.alu = alu; i.rs2 = rs2; i.rdata = rdata;
    i.lat = lat; i.pc4 = $urandom;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    int   kind;
    i = mk(1'b1, 5'($urandom), 1'b0, 1'b0, 1'b0, 2'b00, 2'($urandom_range(0, 2)),
           1'($urandom), $urandom, $urandom, $urandom, 0);
    kind = $urandom_range(0, 9);
    if (kind == 0) begin
      i.valid = 1'b0; i.rw = 1'b1; i.mr = 1'b1;   // bubble with junk control
    end else if (kind <= 3) begin
      i.rw = 1'b1;                                // ALU op
    end else if (kind == 4) begin
      i.rw = 1'b1; i.sel = 2'b10;                 // JAL/JALR link
    end else begin
      if (kind <= 7) begin
        i.rw = 1'b1; i.mr = 1'b1; i.sel = 2'b01;  // load
      end else begin
        i.mw = 1'b1;                              // store
      end
      i.lat = ($urandom_range(0, 12) == 0) ? -1 : $urandom_range(0, 3);
    end
    return i;
  endfunction

  // Expected values straight from the access-size rules.
  function automatic bit [3:0] exp_be(input ins_t i);
    if (i.size == 2'b00) return 4'(1 << i.alu[1:0]);
    if (i.size == 2'b01) return i.alu[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic bit [31:0] exp_wdata(input ins_t i);
    if (i.size == 2'b00) return {24'd0, i.rs2[7:0]} * 32'h0101_0101;
    if (i.size == 2'b01) return {16'd0, i.rs2[15:0]} * 32'h0001_0001;
    return i.rs2;
  endfunction

  function automatic bit [31:0] wb_val(input ins_t i, input bit [31:0] raw);
    bit [31:0] sh, v;
    if (i.sel == 2'b10) return i.pc4;
    if (i.sel != 2'b01) return i.alu;
    sh = raw >> (8 * i.alu[1:0]);
    if (i.size == 2'b00) begin
      v = sh & 32'hFF;
      if (i.sgn && sh[7]) v = v + 32'hFFFF_FF00;
    end else if (i.size == 2'b01) begin
      v = sh & 32'hFFFF;
      if (i.sgn && sh[15]) v = v + 32'hFFFF_0000;
    end else begin
      v = sh;
    end
    return v;
  endfunction

  task automatic model_reset();
    em = blank(); k = 0; m_rd = 5'd0; m_rw = 1'b0; m_data = 32'd0; m_berr = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_req"},   32'(dmem_req),        32'd0);
    check({pfx, "_we"},    32'(dmem_we),         32'd0);
    check({pfx, "_addr"},  dmem_addr,            32'd0);
    check({pfx, "_be"},    32'(dmem_be),         32'd0);
    check({pfx, "_wdata"}, dmem_wdata,           32'd0);
    check({pfx, "_stall"}, 32'(mem_stall),       32'd0);
    check({pfx, "_emrd"},  32'(ex_mem_rd),       32'd0);
    check({pfx, "_emrw"},  32'(ex_mem_regWrite), 32'd0);
    check({pfx, "_fwd"},   ex_mem_fwd_data,      32'd0);
    check({pfx, "_mwrd"},  32'(mem_wb_rd),       32'd0);
    check({pfx, "_mwrw"},  32'(mem_wb_regWrite), 32'd0);
    check({pfx, "_wb"},    wb_data,              32'd0);
    check({pfx, "_berr"},  32'(bus_err),         32'd0);
  endtask

  // One clock cycle: entered and left 1 time unit after a rising edge.
  task automatic do_cycle();
    ins_t      nx;
    bit        memop, ack, tout, stall;
    bit [31:0] raw;
    nx = (q.size() > 0) ? q[0] : mk(1'b0, 5'($urandom), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
                                    1'b0, $urandom, $urandom, 32'd0, 0);
    ex_valid = nx.valid; ex_rd = nx.rd; ex_regWrite = nx.rw; ex_memRead = nx.mr;
    ex_memWrite = nx.mw; ex_rf_wr_sel = nx.sel; ex_size = nx.size; ex_sign = nx.sgn;
    ex_alu_result = nx.alu; ex_rs2_data = nx.rs2; ex_pc_plus4 = nx.pc4;

    memop = em.valid && (em.mr || em.mw);
    ack   = memop ? (em.lat >= 0 && k == em.lat) : 1'($urandom);
    tout  = memop && em.lat < 0 && k == TO;   // TO+1 request cycles, then give up
    stall = memop && !ack && !tout;
    raw   = memop ? em.rdata : $urandom;
    dmem_ack = ack; dmem_rdata = raw;
    #1;

    check("req",   32'(dmem_req),        32'(memop));
    check("stall", 32'(mem_stall),       32'(stall));
    check("em_rd", 32'(ex_mem_rd),       32'(em.rd));
    check("em_rw", 32'(ex_mem_regWrite), 32'(em.rw));
    check("fwd",   ex_mem_fwd_data,      (em.sel == 2'b10) ? em.pc4 : em.alu);
    check("mw_rd", 32'(mem_wb_rd),       32'(m_rd));
    check("mw_rw", 32'(mem_wb_regWrite), 32'(m_rw));
    if (m_rw) check("wb", wb_data, m_data);
    check("berr",  32'(bus_err),         32'(m_berr));
    if (memop) begin
      check("we",    32'(dmem_we), 32'(em.mw));
      check("addr",  dmem_addr,    {em.alu[31:2], 2'b00});
      check("be",    32'(dmem_be), 32'(exp_be(em)));
      if (em.mw) check("wdata", dmem_wdata, exp_wdata(em));
    end

    if (!stall) begin
      m_rd = em.rd; m_rw = em.rw && !tout; m_data = wb_val(em, raw);
      if (tout) m_berr = 1'b1;
      em = nx;
      if (!em.valid) begin em.rw = 1'b0; em.mr = 1'b0; em.mw = 1'b0; end
      k = 0;
      if (q.size() > 0) void'(q.pop_front());
    end else begin
      k++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 0; ex_rd = 0; ex_regWrite = 0; ex_memRead = 0; ex_memWrite = 0;
    ex_rf_wr_sel = 0; ex_size = 0; ex_sign = 0; ex_alu_result = 0; ex_rs2_data = 0;
    ex_pc_plus4 = 0; dmem_ack = 0; dmem_rdata = 0;
    model_reset();
    #12;
    check_all_zero("rst0");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases first, then a random stream.
    //         v  rd  rw mr mw sel    size   sgn alu           rs2           rdata         lat
    q.push_back(mk(1, 5,  1, 0, 0, 2'b00, 2'b10, 0, 32'h0000_1234, 32'h0,        32'h0,        0));  // ADD
    q.push_back(mk(1, 6,  1, 1, 0, 2'b01, 2'b00, 1, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0)); // LB zero-wait
    q.push_back(mk(1, 0,  0, 0, 1, 2'b00, 2'b01, 0, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        3));  // SH 3 waits
    q.push_back(mk(0, 9,  1, 0, 0, 2'b00, 2'b10, 0, 32'h0000_0055, 32'h0,        32'h0,        0));  // bubble
    q.push_back(mk(0, 10, 1, 1, 0, 2'b01, 2'b10, 0, 32'h0000_0066, 32'h0,        32'h0,        0));  // bubble
    q.push_back(mk(1, 11, 1, 1, 0, 2'b01, 2'b10, 0, 32'h0000_0300, 32'h0,        32'hDEAD_BEEF, -1)); // LW timeout
    q.push_back(mk(1, 12, 1, 0, 0, 2'b00, 2'b10, 0, 32'h0000_0077, 32'h0,        32'h0,        0));  // proceeds
    for (int i = 0; i < 300; i++) q.push_back(rand_ins());

    for (int i = 0; i < 3000 && q.size() > 0; i++) do_cycle();
    if (q.size() > 0) check("drain", 32'(q.size()), 32'd0);
    for (int i = 0; i < 20 && em.valid && (em.mr || em.mw); i++) do_cycle();
    do_cycle();

    // Async reset while a never-acked load sits in WAIT.
    q.push_back(mk(1, 13, 1, 1, 0, 2'b01, 2'b10, 0, 32'h0000_0400, 32'h0, 32'h0, -1));
    do_cycle();   // capture
    do_cycle();   // first request cycle
    do_cycle();   // now in WAIT
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 40; i++) q.push_back(rand_ins());
    for (int i = 0; i < 600 && q.size() > 0; i++) do_cycle();
    if (q.size() > 0) check("drain2", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
